// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
//   Request/response bundle for the branch resolver.
//
//   Request channel (master -> slave, valid/ready):
//     req_valid, req_ready (back), funct3[2:0], rs1[W-1:0], rs2[W-1:0],
//     pc[PCW-1:0], imm[PCW-1:0]
//   Response channel (slave -> master, valid/ready):
//     rsp_valid, rsp_ready (back), taken, target[PCW-1:0],
//     next_pc[PCW-1:0], illegal
//
//   master : the execute stage issuing branches
//   slave  : branch_resolve_unit
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if #(
  parameter int W   = 32,
  parameter int PCW = 32
);

  logic           req_valid;
  logic           req_ready;
  logic [2:0]     funct3;
  logic [W-1:0]   rs1;
  logic [W-1:0]   rs2;
  logic [PCW-1:0] pc;
  logic [PCW-1:0] imm;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           taken;
  logic [PCW-1:0] target;
  logic [PCW-1:0] next_pc;
  logic           illegal;

  modport master (
    output req_valid, funct3, rs1, rs2, pc, imm, rsp_ready,
    input  req_ready, rsp_valid, taken, target, next_pc, illegal
  );

  modport slave (
    input  req_valid, funct3, rs1, rs2, pc, imm, rsp_ready,
    output req_ready, rsp_valid, taken, target, next_pc, illegal
  );

endinterface

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Multi-cycle RISC-V branch-condition resolver. Operands are compared
//   CHUNK bits per cycle starting at the MSB; the first differing chunk
//   ends the scan early. The result drives taken / target / next_pc.
//
//   Parameters:
//     W     operand width (must be a multiple of CHUNK)
//     CHUNK bits compared per scan cycle (CHUNK == W -> single-cycle scan)
//     PCW   PC / immediate width
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    branch_resolve_unit_if.slave (request + response channels)
//
//   State | Meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; response outputs hold their last values
//   SCAN  | comparing one chunk per cycle, MSB chunk first
//   RESP  | response valid and held until rsp_ready
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int W     = 32,
  parameter int CHUNK = 8,
  parameter int PCW   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  bus
);

  localparam int NCHUNK = W / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
  // XOR mask flipping only the operand MSB (signed -> offset-binary)
  localparam logic [W-1:0]    MSB_MASK = W'(1) << (W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  // captured request
  logic [IDXW-1:0] idx_q;
  logic [2:0]      funct3_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [PCW-1:0]  target_q;
  logic [PCW-1:0]  pc4_q;

  // registered response
  logic            taken_r;
  logic            illegal_r;
  logic [PCW-1:0]  target_r;
  logic [PCW-1:0]  next_pc_r;

  // request decode
  logic            accept;
  logic            req_illegal;
  logic            req_signed;
  logic [PCW-1:0]  req_target;
  logic [PCW-1:0]  req_pc4;

  // chunk compare
  logic [NCHUNK-1:0][CHUNK-1:0] a_arr;
  logic [NCHUNK-1:0][CHUNK-1:0] b_arr;
  logic [IDXW-1:0] sel;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic            chunk_diff;
  logic            chunk_lt;
  logic            last_chunk;
  logic            scan_done;
  logic            res_eq;
  logic            res_lt;
  logic            res_taken;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  assign accept      = bus.req_valid && (state_q == IDLE);
  assign req_illegal = (bus.funct3[2:1] == 2'b01);
  assign req_signed  = (bus.funct3[2:1] == 2'b10);
  assign req_target  = bus.pc + bus.imm;
  assign req_pc4     = bus.pc + PCW'(4);

  // -------------------------------------------------------------------------
  // Chunk compare. idx_q counts scan steps from the MSB chunk; the packed
  // array is numbered from the LSB, hence the reversal.
  // -------------------------------------------------------------------------
  assign a_arr      = a_q;
  assign b_arr      = b_q;
  assign sel        = LAST_IDX - idx_q;
  assign a_chunk    = a_arr[sel];
  assign b_chunk    = b_arr[sel];
  assign chunk_diff = (a_chunk != b_chunk);
  assign chunk_lt   = (a_chunk < b_chunk);
  assign last_chunk = (idx_q == LAST_IDX);
  assign scan_done  = chunk_diff || last_chunk;

  // Result of the scan step that ends it: a differing chunk decides lt,
  // reaching the last chunk without a difference means equal.
  assign res_eq = !chunk_diff;
  assign res_lt = chunk_diff && chunk_lt;

  always_comb begin
    res_taken = 1'b0;
    case (funct3_q)
      3'b000:         res_taken = res_eq;
      3'b001:         res_taken = !res_eq;
      3'b100, 3'b110: res_taken = res_lt;
      3'b101, 3'b111: res_taken = !res_lt;
      default:        res_taken = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_illegal ? RESP : SCAN;
        end
      end
      SCAN: begin
        if (scan_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.taken     = taken_r;
    bus.target    = target_r;
    bus.next_pc   = next_pc_r;
    bus.illegal   = illegal_r;
  end

  // -------------------------------------------------------------------------
  // Datapath: request capture, scan index, response registers.
  // Response registers only change on entry to RESP, so they are stable for
  // the whole response and keep their values through IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      funct3_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      target_q  <= '0;
      pc4_q     <= '0;
      taken_r   <= 1'b0;
      illegal_r <= 1'b0;
      target_r  <= '0;
      next_pc_r <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q    <= '0;
            funct3_q <= bus.funct3;
            // Flipping both MSBs makes the unsigned scan order match signed order.
            a_q      <= bus.rs1 ^ (req_signed ? MSB_MASK : '0);
            b_q      <= bus.rs2 ^ (req_signed ? MSB_MASK : '0);
            target_q <= req_target;
            pc4_q    <= req_pc4;
            if (req_illegal) begin
              taken_r   <= 1'b0;
              illegal_r <= 1'b1;
              target_r  <= req_target;
              next_pc_r <= req_pc4;
            end
          end
        end
        SCAN: begin
          if (scan_done) begin
            taken_r   <= res_taken;
            illegal_r <= 1'b0;
            target_r  <= target_q;
            next_pc_r <= res_taken ? target_q : pc4_q;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int W      = 32;
  localparam int CHUNK  = 8;
  localparam int PCW    = 32;
  localparam int NCHUNK = W / CHUNK;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.W(W), .PCW(PCW)) bus ();

  branch_resolve_unit #(.W(W), .CHUNK(CHUNK), .PCW(PCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic           taken;
    logic [PCW-1:0] target;
    logic [PCW-1:0] next_pc;
    logic           illegal;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  always @(posedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) hs_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [PCW-1:0] p,
                                 input logic [PCW-1:0] i);
    exp_t e;
    logic eq, lt, tk;
    int   n;
    logic [W-1:0] x;
    e.target  = p + i;
    e.illegal = (f3 == 3'b010) || (f3 == 3'b011);
    eq = (a == b);
    if (f3 == 3'b100 || f3 == 3'b101) lt = ($signed(a) < $signed(b));
    else                              lt = (a < b);
    case (f3)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default:        tk = 1'b0;
    endcase
    e.taken = tk;
    n = NCHUNK;
    x = a ^ b;
    for (int k = NCHUNK - 1; k >= 0; k--) begin
      if (((x >> ((NCHUNK - 1 - k) * CHUNK)) & W'((1 << CHUNK) - 1)) != 0) n = k + 1;
    end
    e.lat     = e.illegal ? 1 : n + 1;
    e.next_pc = tk ? e.target : p + 32'd4;
    return e;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", bus.req_ready, 1'b1);
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [PCW-1:0] p, input logic [PCW-1:0] i);
    bus.funct3    = f3;
    bus.rs1       = a;
    bus.rs2       = b;
    bus.pc        = p;
    bus.imm       = i;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the handshake.
  task automatic run_txn(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [PCW-1:0] p, input logic [PCW-1:0] i, input int hold);
    exp_t e;
    int lat;
    int hs0;
    sb.push_back(model(f3, a, b, p, i));
    wait_ready();
    hs0 = hs_cnt;
    bus.rsp_ready = (hold == 0);
    drive_req(f3, a, b, p, i);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.rsp_valid) check("busy_req_ready", bus.req_ready, 1'b0);
    end while (!bus.rsp_valid && lat < 40);
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("taken", bus.taken, e.taken);
    check("target", bus.target, e.target);
    check("next_pc", bus.next_pc, e.next_pc);
    check("illegal", bus.illegal, e.illegal);
    check("resp_req_ready", bus.req_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_taken", bus.taken, e.taken);
      check("hold_target", bus.target, e.target);
      check("hold_next_pc", bus.next_pc, e.next_pc);
      check("hold_req_ready", bus.req_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_dropped", bus.rsp_valid, 1'b0);
    check("handshakes", hs_cnt - hs0, 1);
    check("idle_req_ready", bus.req_ready, 1'b1);
    check("idle_keep_next_pc", bus.next_pc, e.next_pc);
  endtask

  // Reset in the second SCAN cycle (in_resp=0) or during a stalled response.
  task automatic reset_mid(input bit in_resp);
    int hs0;
    int seen = 0;
    wait_ready();
    hs0 = hs_cnt;
    bus.rsp_ready = 1'b0;
    drive_req(3'b000, 32'h5555AAAA, 32'h5555AAAA, 32'h400, 32'h8);
    @(negedge clk);
    @(negedge clk);
    if (in_resp) begin
      repeat (4) @(negedge clk);
      check("pre_reset_valid", bus.rsp_valid, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_taken", bus.taken, 1'b0);
    check("rst_next_pc", bus.next_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("no_spurious", seen, 0);
    check("rst_handshakes", hs_cnt - hs0, 0);
    check("post_rst_ready", bus.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]     f3_tab [6];
    logic [2:0]     f3;
    logic [W-1:0]   a, b;
    logic [CHUNK-1:0] r;
    int             k;

    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b100;
    f3_tab[3] = 3'b101; f3_tab[4] = 3'b110; f3_tab[5] = 3'b111;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.funct3    = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.pc        = '0;
    bus.imm       = '0;
    #2;
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_taken", bus.taken, 1'b0);
    check("reset_target", bus.target, 32'h0);
    check("reset_next_pc", bus.next_pc, 32'h0);
    check("reset_illegal", bus.illegal, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h100, 32'h20, 0);      // BLT
    run_txn(3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h100, 32'h20, 0);      // BLTU
    run_txn(3'b000, 32'h12345678, 32'h12345678, 32'h300, 32'h40, 0);      // BEQ
    run_txn(3'b101, 32'h12345678, 32'h12345678, 32'h300, 32'h40, 0);      // BGE
    run_txn(3'b100, 32'h12345678, 32'h12345678, 32'h300, 32'h40, 0);      // BLT
    run_txn(3'b001, 32'h12345678, 32'h12345679, 32'h500, 32'hFFFFFFF0, 3); // BNE, stall
    run_txn(3'b010, 32'h0, 32'h0, 32'h200, 32'h10, 0);                    // illegal
    run_txn(3'b011, 32'h1, 32'h1, 32'h240, 32'h8, 1);                     // illegal
    run_txn(3'b000, 32'hCAFEF00D, 32'hCAFEF00D, 32'hFFFFFFF0, 32'h20, 0); // wrap
    run_txn(3'b111, 32'h00FF0000, 32'h00FE0000, 32'h600, 32'h4, 0);       // BGEU 2nd chunk
    run_txn(3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h700, 32'h100, 0);     // BGE neg vs pos

    reset_mid(1'b0);
    run_txn(3'b001, 32'h0, 32'h0, 32'h800, 32'h40, 0);                    // BNE after reset
    reset_mid(1'b1);
    run_txn(3'b110, 32'h00000010, 32'h00000020, 32'h900, 32'h80, 0);      // BLTU last chunk

    for (int t = 0; t < 24; t++) begin
      f3 = f3_tab[$urandom_range(0, 5)];
      a  = $urandom;
      b  = a;
      k  = $urandom_range(0, NCHUNK - 1);
      r  = CHUNK'($urandom);
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        default: b = a ^ (W'(r) << (k * CHUNK));
      endcase
      run_txn(f3, a, b, $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Multi-cycle branch-condition resolver for the RISC-V execute stage; consumes the comparison result rather than only producing it.
- Accepts rs1/rs2, funct3, PC and sign-extended immediate over a valid/ready request channel.
- Compares operands CHUNK bits per cycle from the MSB down, with early exit on the first differing chunk.
- Returns taken, branch target and next PC over a valid/ready response channel.

Parameters:
- W, 32: operand width; W % CHUNK must be 0.
- CHUNK, 8: bits compared per scan cycle; CHUNK = W gives a single-cycle scan.
- PCW, 32: PC/immediate width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  unit can accept a request.
- funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- rs1  input  W  operand a.
- rs2  input  W  operand b.
- pc  input  PCW  branch instruction PC.
- imm  input  PCW  sign-extended B-immediate.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- taken  output  1  branch condition true.
- target  output  PCW  pc + imm.
- next_pc  output  PCW  taken ? target : pc + 4.
- illegal  output  1  funct3 is 010 or 011.

Behaviour:
- Reset (async, rst_n low): state IDLE, chunk index 0, rsp_valid=0, taken=0, target=0, next_pc=0, illegal=0. req_ready reads 1 while in reset.
- req_ready = 1 only in IDLE. A request is accepted when req_valid && req_ready at a rising edge.
- On accept, capture funct3, pc+imm and pc+4, both modulo 2^PCW.
- Signed compare (funct3 100/101): capture rs1 and rs2 with their MSB inverted, so the unsigned scan yields the signed result. Other funct3 values capture the operands unmodified.
- FSM:
  - IDLE: on accept with legal funct3, go to SCAN with index = 0 (MSB chunk). On accept with illegal funct3, go to RESP with illegal=1, taken=0.
  - SCAN: each cycle compare chunk bits [W-1-k*CHUNK -: CHUNK] of both operands.
    - If the chunks differ: record lt = (a_chunk < b_chunk), eq=0, go to RESP.
    - Else if this is the last chunk: eq=1, lt=0, go to RESP.
    - Else: index++.
  - RESP: rsp_valid=1. taken, target, next_pc and illegal are registered and held stable while rsp_valid && !rsp_ready. On rsp_ready go to IDLE.
- Condition decode:
  - BEQ: eq.
  - BNE: !eq.
  - BLT and BLTU: lt.
  - BGE and BGEU: !lt.
- next_pc = taken ? target : pc + 4. target is reported even when not taken.
- Latency: with the accept in cycle 0 and the deciding chunk at scan step n (1..W/CHUNK), rsp_valid is high from cycle n+1. An illegal funct3 gives rsp_valid in cycle 1.
- Response handshake: new requests are not accepted in SCAN or RESP, so there is no overlap. With rsp_ready tied high the next accept can happen the cycle after the response handshake.
- Outputs other than rsp_valid keep their last values in IDLE.
- Reset mid-operation (SCAN or RESP): the transaction is dropped, rsp_valid falls immediately (async), and no response is issued after reset release.
- req_valid is ignored outside IDLE; the requester holds the request until req_ready.

Test Plan:
- BLT: rs1=0xFFFFFFFF, rs2=0x00000001, pc=0x100, imm=0x20 -> MSB chunk decides, rsp_valid in cycle 2, taken=1, target=0x120, next_pc=0x120.
- BLTU with the same operands -> rsp_valid in cycle 2, taken=0, target=0x120, next_pc=0x104.
- BEQ: rs1=rs2=0x12345678 -> 4 scan cycles, rsp_valid in cycle 5, taken=1.
  - BGE with the same operands -> taken=1.
  - BLT with the same operands -> taken=0.
- BNE: rs1=0x12345678, rs2=0x12345679 -> decided on the last chunk, rsp_valid in cycle 5, taken=1.
  - Hold rsp_ready=0 for 3 cycles: outputs stay stable, req_ready=0 throughout, exactly one handshake.
- Illegal and wrap cases:
  - funct3=010, pc=0x200 -> rsp_valid in cycle 1, illegal=1, taken=0, next_pc=0x204.
  - BEQ with pc=0xFFFFFFF0, imm=0x20, equal operands -> target=0x00000010.
- Reset: assert rst_n=0 in the second SCAN cycle -> rsp_valid=0 immediately, req_ready=1 after release, no spurious response.
  - A following BNE with rs1=0, rs2=0 then completes normally with taken=0.
